// File: rtl/usb_link_ctrl_pkg.sv
// Shared types and constants for the USB device link-layer controller.
package usb_link_ctrl_pkg;

    // Full-speed device; clearing this swaps the J/K encodings for low speed.
    localparam bit USB_FULL_SPEED = 1'b1;

    // Pad value as {dp, dm}.
    typedef logic [1:0] d_port_t;

    localparam d_port_t SE0_STATE = 2'b00;
    localparam d_port_t SE1_STATE = 2'b11;
    localparam d_port_t J_STATE   = USB_FULL_SPEED ? 2'b10 : 2'b01;
    localparam d_port_t K_STATE   = USB_FULL_SPEED ? 2'b01 : 2'b10;

    typedef enum logic [2:0] {
        DETACHED,
        ATTACHED,
        BUS_RESET,
        SUSPENDED,
        RESUMING
    } link_state_t;

    // Used at elaboration time to size the counters from the largest timing parameter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_link_ctrl_line_state.sv
// Brings the asynchronous D+/D- pair into the clock domain and decodes it
// into one-hot SE0 / J / K / SE1 line states.
module usb_line_state
    import usb_link_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  d_port_t d_i,
    output logic    se0,
    output logic    j,
    output logic    k,
    output logic    se1
);

    d_port_t d_meta_q, d_meta_d;
    d_port_t d_sync_q, d_sync_d;

    // Two-stage synchronizer feed.
    always_comb begin
        d_meta_d = d_i;
        d_sync_d = d_meta_q;
    end

    // Synchronizer flops, cleared to SE0 on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_meta_q <= SE0_STATE;
            d_sync_q <= SE0_STATE;
        end else begin
            d_meta_q <= d_meta_d;
            d_sync_q <= d_sync_d;
        end
    end

    // Decode the synchronized pair; exactly one output is high.
    always_comb begin
        se0 = (d_sync_q == SE0_STATE);
        j   = (d_sync_q == J_STATE);
        k   = (d_sync_q == K_STATE);
        se1 = (d_sync_q == SE1_STATE);
    end

endmodule

// File: rtl/usb_link_ctrl.sv
// USB device link-layer controller: soft-connect sequencing, bus reset and
// suspend detection, remote-wakeup K signalling and pad driver arbitration.
module usb_link_ctrl
    import usb_link_ctrl_pkg::*;
#(
    parameter int SE0_CYCLES        = 120,
    parameter int IDLE_CYCLES       = 144_000,
    parameter int DETACH_CYCLES     = 480_000,
    parameter int WAKE_DELAY_CYCLES = 240_000,
    parameter int WAKE_CYCLES       = 96_000
) (
    input  logic        clk,
    input  logic        reset,
    input  d_port_t     d_i,
    output d_port_t     d_o,
    output logic        d_en,
    input  d_port_t     sie_d_o,
    input  logic        sie_d_en,
    input  logic        connect,
    input  logic        wakeup_req,
    output logic        pullup_en,
    output logic        usb_reset,
    output logic        suspended,
    output link_state_t link_state
);

    localparam int MAX_CYCLES = max_int(max_int(max_int(SE0_CYCLES, IDLE_CYCLES),
                                                max_int(DETACH_CYCLES, WAKE_DELAY_CYCLES)),
                                        WAKE_CYCLES);
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_MAX        = {CW{1'b1}};
    localparam cnt_t SE0_LIM        = cnt_t'(SE0_CYCLES - 1);
    localparam cnt_t IDLE_LIM       = cnt_t'(IDLE_CYCLES - 1);
    localparam cnt_t DETACH_LIM     = cnt_t'(DETACH_CYCLES - 1);
    localparam cnt_t WAKE_DELAY_LIM = cnt_t'(WAKE_DELAY_CYCLES);
    localparam cnt_t WAKE_LIM       = cnt_t'(WAKE_CYCLES - 1);

    logic        line_se0, line_j, line_k, line_se1;
    logic [3:0]  line_now;
    logic [3:0]  prev_q, prev_d;
    cnt_t        run_q, run_d;
    cnt_t        tmr_q, tmr_d;
    link_state_t state_q, state_d;
    logic        pullup_en_q, pullup_en_d;
    logic        usb_reset_q, usb_reset_d;
    logic        suspended_q, suspended_d;
    logic        se0_hit, j_hit;

    usb_line_state u_line_state (
        .clk   (clk),
        .reset (reset),
        .d_i   (d_i),
        .se0   (line_se0),
        .j     (line_j),
        .k     (line_k),
        .se1   (line_se1)
    );

    // Pad arbitration: own K drive while resuming, SIE passthrough while attached.
    always_comb begin
        d_en = 1'b0;
        d_o  = sie_d_o;
        case (state_q)
            RESUMING: begin
                d_en = 1'b1;
                d_o  = K_STATE;
            end
            ATTACHED: d_en = sie_d_en;
            default: ;
        endcase
    end

    // Run length of the current line state (count of repeats of the sample now on the line), held at zero while we drive the pad.
    always_comb begin
        line_now = {line_se0, line_j, line_k, line_se1};
        prev_d   = line_now;
        if (d_en || (line_now != prev_q)) begin
            run_d = '0;
        end else if (run_q != CNT_MAX) begin
            run_d = run_q + cnt_t'(1);
        end else begin
            run_d = run_q;
        end
        se0_hit = line_se0 && (run_d >= SE0_LIM);
        j_hit   = line_j && (run_d >= IDLE_LIM);
    end

    // Next-state logic, state timer and the decoded status outputs.
    always_comb begin
        state_d = state_q;
        if (!connect) begin
            state_d = DETACHED;
        end else begin
            case (state_q)
                DETACHED:  if (tmr_q >= DETACH_LIM) state_d = ATTACHED;
                ATTACHED: begin
                    if (se0_hit)    state_d = BUS_RESET;
                    else if (j_hit) state_d = SUSPENDED;
                end
                BUS_RESET: if (!line_se0) state_d = ATTACHED;
                SUSPENDED: begin
                    if (se0_hit)     state_d = BUS_RESET;
                    else if (line_k) state_d = ATTACHED;
                    else if (wakeup_req && (tmr_q >= WAKE_DELAY_LIM)) state_d = RESUMING;
                end
                RESUMING:  if (tmr_q == WAKE_LIM) state_d = ATTACHED;
                default:   state_d = DETACHED;
            endcase
        end

        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (tmr_q != CNT_MAX) begin
            tmr_d = tmr_q + cnt_t'(1);
        end else begin
            tmr_d = tmr_q;
        end

        pullup_en_d = (state_d != DETACHED);
        usb_reset_d = (state_d == DETACHED) || (state_d == BUS_RESET);
        suspended_d = (state_d == SUSPENDED);
    end

    // Link FSM state, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DETACHED;
            tmr_q       <= '0;
            run_q       <= '0;
            prev_q      <= '0;
            pullup_en_q <= 1'b0;
            usb_reset_q <= 1'b1;
            suspended_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            run_q       <= run_d;
            prev_q      <= prev_d;
            pullup_en_q <= pullup_en_d;
            usb_reset_q <= usb_reset_d;
            suspended_q <= suspended_d;
        end
    end

    assign pullup_en  = pullup_en_q;
    assign usb_reset  = usb_reset_q;
    assign suspended  = suspended_q;
    assign link_state = state_q;

endmodule

// File: tb/tb_usb_link_ctrl.sv
// Directed testbench for usb_link_ctrl with shortened timing parameters.
module tb_usb_link_ctrl;
    import usb_link_ctrl_pkg::*;

    localparam d_port_t PAD_J   = 2'b10;
    localparam d_port_t PAD_K   = 2'b01;
    localparam d_port_t PAD_SE0 = 2'b00;

    logic        clk;
    logic        reset;
    d_port_t     d_i;
    d_port_t     d_o;
    logic        d_en;
    d_port_t     sie_d_o;
    logic        sie_d_en;
    logic        connect;
    logic        wakeup_req;
    logic        pullup_en;
    logic        usb_reset;
    logic        suspended;
    link_state_t link_state;

    int total;
    int bad;

    usb_link_ctrl #(
        .SE0_CYCLES        (8),
        .IDLE_CYCLES       (40),
        .DETACH_CYCLES     (20),
        .WAKE_DELAY_CYCLES (30),
        .WAKE_CYCLES       (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_i        (d_i),
        .d_o        (d_o),
        .d_en       (d_en),
        .sie_d_o    (sie_d_o),
        .sie_d_en   (sie_d_en),
        .connect    (connect),
        .wakeup_req (wakeup_req),
        .pullup_en  (pullup_en),
        .usb_reset  (usb_reset),
        .suspended  (suspended),
        .link_state (link_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One K pad cycle breaks any J run, then 42 J pad cycles qualify suspend.
    task automatic go_suspend();
        d_i = PAD_K;
        tick(1);
        d_i = PAD_J;
        tick(41);
        total++;
        if (suspended !== 1'b0) begin
            bad++;
            $display("[TB] FAIL suspend_early got=%b want=0", suspended);
        end
        tick(1);
        total++;
        if (link_state !== SUSPENDED || suspended !== 1'b1) begin
            bad++;
            $display("[TB] FAIL suspend_entry state=%0d susp=%b want state=%0d susp=1",
                     link_state, suspended, SUSPENDED);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; connect = 1'b1; d_i = PAD_J;
        sie_d_o = 2'b00; sie_d_en = 1'b0; wakeup_req = 1'b0;
        tick(2);
        total++;
        if (link_state !== DETACHED) begin
            bad++; $display("[TB] FAIL reset_state got=%0d want=%0d", link_state, DETACHED);
        end
        total++;
        if ({pullup_en, usb_reset, suspended, d_en} !== 4'b0100) begin
            bad++; $display("[TB] FAIL reset_outputs got=%b want=0100",
                            {pullup_en, usb_reset, suspended, d_en});
        end
    endtask

    task automatic test_attach();
        reset = 1'b0;
        tick(19);
        total++;
        if (pullup_en !== 1'b0 || usb_reset !== 1'b1) begin
            bad++; $display("[TB] FAIL attach_early pullup=%b rst=%b want 0 1", pullup_en, usb_reset);
        end
        tick(1);
        total++;
        if (pullup_en !== 1'b1 || usb_reset !== 1'b0 || link_state !== ATTACHED) begin
            bad++; $display("[TB] FAIL attach_at_20 pullup=%b rst=%b state=%0d want 1 0 %0d",
                            pullup_en, usb_reset, link_state, ATTACHED);
        end
    endtask

    task automatic test_short_se0();
        d_i = PAD_SE0;
        tick(7);
        d_i = PAD_J;
        tick(5);
        total++;
        if (usb_reset !== 1'b0 || link_state !== ATTACHED) begin
            bad++; $display("[TB] FAIL short_se0 rst=%b state=%0d want 0 %0d",
                            usb_reset, link_state, ATTACHED);
        end
    endtask

    task automatic test_bus_reset();
        d_i = PAD_SE0;
        tick(9);
        total++;
        if (usb_reset !== 1'b0) begin
            bad++; $display("[TB] FAIL bus_reset_early got=%b want=0", usb_reset);
        end
        tick(1);
        total++;
        if (usb_reset !== 1'b1 || link_state !== BUS_RESET) begin
            bad++; $display("[TB] FAIL bus_reset_at_10 rst=%b state=%0d want 1 %0d",
                            usb_reset, link_state, BUS_RESET);
        end
        d_i = PAD_J;
        tick(2);
        total++;
        if (usb_reset !== 1'b1) begin
            bad++; $display("[TB] FAIL bus_reset_hold got=%b want=1", usb_reset);
        end
        tick(1);
        total++;
        if (usb_reset !== 1'b0 || link_state !== ATTACHED) begin
            bad++; $display("[TB] FAIL bus_reset_exit rst=%b state=%0d want 0 %0d",
                            usb_reset, link_state, ATTACHED);
        end
    endtask

    task automatic test_host_resume();
        go_suspend();
        sie_d_en = 1'b1; sie_d_o = 2'b01;
        #1;
        total++;
        if (d_en !== 1'b0 || d_o !== 2'b01) begin
            bad++; $display("[TB] FAIL arb_suspend d_en=%b d_o=%b want 0 01", d_en, d_o);
        end
        d_i = PAD_K;
        tick(2);
        total++;
        if (suspended !== 1'b1 || d_en !== 1'b0) begin
            bad++; $display("[TB] FAIL resume_sync susp=%b d_en=%b want 1 0", suspended, d_en);
        end
        tick(1);
        total++;
        if (suspended !== 1'b0 || link_state !== ATTACHED || d_en !== 1'b1) begin
            bad++; $display("[TB] FAIL resume_k susp=%b state=%0d d_en=%b want 0 %0d 1",
                            suspended, link_state, d_en, ATTACHED);
        end
        sie_d_en = 1'b0; sie_d_o = 2'b10;
        #1;
        total++;
        if (d_en !== 1'b0 || d_o !== 2'b10) begin
            bad++; $display("[TB] FAIL sie_passthru d_en=%b d_o=%b want 0 10", d_en, d_o);
        end
    endtask

    task automatic test_remote_wakeup();
        go_suspend();
        tick(10);
        wakeup_req = 1'b1; tick(1); wakeup_req = 1'b0;
        total++;
        if (link_state !== SUSPENDED || d_en !== 1'b0) begin
            bad++; $display("[TB] FAIL wake_too_early state=%0d d_en=%b want %0d 0",
                            link_state, d_en, SUSPENDED);
        end
        tick(19);
        wakeup_req = 1'b1; tick(1); wakeup_req = 1'b0;
        total++;
        if (link_state !== RESUMING || d_en !== 1'b1 || d_o !== 2'b01) begin
            bad++; $display("[TB] FAIL wake_start state=%0d d_en=%b d_o=%b want %0d 1 01",
                            link_state, d_en, d_o, RESUMING);
        end
        for (int i = 1; i < 16; i++) begin
            tick(1);
            total++;
            if (d_en !== 1'b1 || d_o !== 2'b01) begin
                bad++; $display("[TB] FAIL wake_k_cycle%0d d_en=%b d_o=%b want 1 01", i, d_en, d_o);
            end
        end
        tick(1);
        total++;
        if (link_state !== ATTACHED || d_en !== 1'b0) begin
            bad++; $display("[TB] FAIL wake_end state=%0d d_en=%b want %0d 0",
                            link_state, d_en, ATTACHED);
        end
    endtask

    task automatic test_k_beats_wakeup();
        go_suspend();
        tick(30);
        d_i = PAD_K;
        tick(2);
        wakeup_req = 1'b1; tick(1); wakeup_req = 1'b0;
        total++;
        if (link_state !== ATTACHED || d_en !== 1'b0) begin
            bad++; $display("[TB] FAIL k_vs_wake state=%0d d_en=%b want %0d 0",
                            link_state, d_en, ATTACHED);
        end
    endtask

    task automatic test_se0_beats_wakeup();
        go_suspend();
        tick(25);
        d_i = PAD_SE0;
        tick(9);
        total++;
        if (link_state !== SUSPENDED) begin
            bad++; $display("[TB] FAIL se0_susp_early state=%0d want %0d", link_state, SUSPENDED);
        end
        wakeup_req = 1'b1; tick(1); wakeup_req = 1'b0;
        total++;
        if (link_state !== BUS_RESET || usb_reset !== 1'b1 || d_en !== 1'b0) begin
            bad++; $display("[TB] FAIL se0_vs_wake state=%0d rst=%b d_en=%b want %0d 1 0",
                            link_state, usb_reset, d_en, BUS_RESET);
        end
        d_i = PAD_J;
        tick(3);
    endtask

    task automatic test_detach_in_resume();
        go_suspend();
        tick(30);
        wakeup_req = 1'b1; tick(1); wakeup_req = 1'b0;
        tick(3);
        connect = 1'b0;
        tick(1);
        total++;
        if (d_en !== 1'b0 || pullup_en !== 1'b0 || usb_reset !== 1'b1 || link_state !== DETACHED) begin
            bad++; $display("[TB] FAIL detach d_en=%b pullup=%b rst=%b state=%0d want 0 0 1 %0d",
                            d_en, pullup_en, usb_reset, link_state, DETACHED);
        end
        connect = 1'b1;
        tick(19);
        total++;
        if (pullup_en !== 1'b0) begin
            bad++; $display("[TB] FAIL reattach_early got=%b want=0", pullup_en);
        end
        tick(1);
        total++;
        if (pullup_en !== 1'b1 || link_state !== ATTACHED) begin
            bad++; $display("[TB] FAIL reattach pullup=%b state=%0d want 1 %0d",
                            pullup_en, link_state, ATTACHED);
        end
    endtask

    task automatic test_reset_mid_resume();
        go_suspend();
        tick(30);
        wakeup_req = 1'b1; tick(1); wakeup_req = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        total++;
        if (d_en !== 1'b0 || link_state !== DETACHED || pullup_en !== 1'b0 || usb_reset !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_mid_resume d_en=%b state=%0d pullup=%b rst=%b want 0 %0d 0 1",
                            d_en, link_state, pullup_en, usb_reset, DETACHED);
        end
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_attach();
        test_short_se0();
        test_bus_reset();
        test_host_resume();
        test_remote_wakeup();
        test_k_beats_wakeup();
        test_se0_beats_wakeup();
        test_detach_in_resume();
        test_reset_mid_resume();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
